vga_timing_param: RTL and testbench

- Parametrised successor to the fixed 800x600 VGA timing generator.
- Produces hcount/vcount, hsync/vsync and hblnk/vblnk for any resolution and porch set, with per-axis sync polarity.
- Adds a frame_start pulse and a free-running frame counter.
- Sits at the head of the VGA pipeline and feeds draw_bg and later drawing stages; all outputs are registered.

---
 rtl/vga_timing_param.sv | 182 ++++++++++++++++++
 tb/tb_vga_timing_param.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/vga_timing_param.sv
// ----------------------------------------------------------------------------
// vga_timing_param
//   Parametrised VGA raster timing generator. Produces the pixel position
//   (hcount/vcount), sync pulses with per-axis polarity, blanking flags, a
//   frame_start pulse and a free-running completed-frame counter. Every output
//   is registered and decoded from the next count values, so the flags are
//   coherent with the position presented in the same cycle.
//
//   Optional feature: define VGA_TIMING_CE_EN to add the pixel-enable input
//   ce. All state then advances only on ce=1 cycles; frame_start reads 0 after
//   ce=0 edges so it lasts exactly one ce-qualified cycle.
//
//   Ports:
//     clk          in   pixel (or system) clock
//     rst          in   synchronous reset, active high
//     ce           in   pixel enable (VGA_TIMING_CE_EN only)
//     hcount       out  horizontal position, 0..H_TOTAL-1
//     vcount       out  vertical position,   0..V_TOTAL-1
//     hsync        out  horizontal sync, active level H_SYNC_POL
//     vsync        out  vertical sync,   active level V_SYNC_POL
//     hblnk        out  horizontal blanking (hcount >= H_ACTIVE)
//     vblnk        out  vertical blanking   (vcount >= V_ACTIVE)
//     frame_start  out  one-cycle pulse on the wrap to (0,0)
//     frame_cnt    out  completed-frame counter, wraps
// ----------------------------------------------------------------------------
module vga_timing_param #(
    parameter int unsigned CNT_W      = 11,
    parameter int unsigned H_ACTIVE   = 800,
    parameter int unsigned H_FP       = 40,
    parameter int unsigned H_SYNC     = 128,
    parameter int unsigned H_BP       = 88,
    parameter int unsigned V_ACTIVE   = 600,
    parameter int unsigned V_FP       = 1,
    parameter int unsigned V_SYNC     = 4,
    parameter int unsigned V_BP       = 23,
    parameter bit          H_SYNC_POL = 1'b1,
    parameter bit          V_SYNC_POL = 1'b1,
    parameter int unsigned FRAME_W    = 8
) (
    input  logic               clk,
    input  logic               rst,
`ifdef VGA_TIMING_CE_EN
    input  logic               ce,
`endif
    output logic [CNT_W-1:0]   hcount,
    output logic [CNT_W-1:0]   vcount,
    output logic               hsync,
    output logic               vsync,
    output logic               hblnk,
    output logic               vblnk,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame_cnt
);

    // ------------------------------------------------------------------------
    // Derived geometry
    // ------------------------------------------------------------------------
    localparam int unsigned H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned H_SYNC_BEG = H_ACTIVE + H_FP;
    localparam int unsigned H_SYNC_END = H_ACTIVE + H_FP + H_SYNC;
    localparam int unsigned V_SYNC_BEG = V_ACTIVE + V_FP;
    localparam int unsigned V_SYNC_END = V_ACTIVE + V_FP + V_SYNC;

    localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT_C   = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_C   = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] H_SBEG_C  = CNT_W'(H_SYNC_BEG);
    localparam logic [CNT_W-1:0] H_SEND_C  = CNT_W'(H_SYNC_END);
    localparam logic [CNT_W-1:0] V_SBEG_C  = CNT_W'(V_SYNC_BEG);
    localparam logic [CNT_W-1:0] V_SEND_C  = CNT_W'(V_SYNC_END);

    // ------------------------------------------------------------------------
    // Elaboration checks: zero-width porches/syncs and totals that overflow
    // the counters would silently produce a broken raster.
    // ------------------------------------------------------------------------
    if (H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
        V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_porch
        $fatal(1, "vga_timing_param: porch and sync widths must be non-zero");
    end

    if ((64'(H_TOTAL) > (64'(1) << CNT_W)) ||
        (64'(V_TOTAL) > (64'(1) << CNT_W))) begin : g_bad_width
        $fatal(1, "vga_timing_param: H_TOTAL/V_TOTAL do not fit in CNT_W bits");
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    logic [CNT_W-1:0]   hcount_q,      hcount_d;
    logic [CNT_W-1:0]   vcount_q,      vcount_d;
    logic               hsync_q,       hsync_d;
    logic               vsync_q,       vsync_d;
    logic               hblnk_q,       hblnk_d;
    logic               vblnk_q,       vblnk_d;
    logic               frame_start_q, frame_start_d;
    logic [FRAME_W-1:0] frame_cnt_q,   frame_cnt_d;

    // Advance qualifier: pixel enable when present, otherwise every cycle.
    logic adv_c;
`ifdef VGA_TIMING_CE_EN
    assign adv_c = ce;
`else
    assign adv_c = 1'b1;
`endif

    // ------------------------------------------------------------------------
    // Next-state: counters first, then every flag decoded from the next counts
    // so that flags and position are presented together.
    // ------------------------------------------------------------------------
    always_comb begin
        hcount_d      = hcount_q;
        vcount_d      = vcount_q;
        frame_cnt_d   = frame_cnt_q;
        frame_start_d = 1'b0;

        if (adv_c) begin
            if (hcount_q == H_LAST) begin
                hcount_d = '0;
                if (vcount_q == V_LAST) begin
                    // Wrap from the last pixel of the frame: one frame done.
                    vcount_d      = '0;
                    frame_start_d = 1'b1;
                    frame_cnt_d   = frame_cnt_q + FRAME_W'(1);
                end else begin
                    vcount_d = vcount_q + CNT_W'(1);
                end
            end else begin
                hcount_d = hcount_q + CNT_W'(1);
            end
        end

        // On hold cycles the counts are unchanged, so these decodes reproduce
        // the held flag values.
        hblnk_d = (hcount_d >= H_ACT_C);
        vblnk_d = (vcount_d >= V_ACT_C);
        hsync_d = ((hcount_d >= H_SBEG_C) && (hcount_d < H_SEND_C)) ?
                  H_SYNC_POL : ~H_SYNC_POL;
        // vcount only moves with the hcount wrap, so vsync changes at hcount=0.
        vsync_d = ((vcount_d >= V_SBEG_C) && (vcount_d < V_SEND_C)) ?
                  V_SYNC_POL : ~V_SYNC_POL;
    end

    // ------------------------------------------------------------------------
    // Registers with synchronous reset; reset wins over ce.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            hcount_q      <= '0;
            vcount_q      <= '0;
            hsync_q       <= ~H_SYNC_POL;
            vsync_q       <= ~V_SYNC_POL;
            hblnk_q       <= 1'b0;
            vblnk_q       <= 1'b0;
            frame_start_q <= 1'b0;
            frame_cnt_q   <= '0;
        end else begin
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            hblnk_q       <= hblnk_d;
            vblnk_q       <= vblnk_d;
            frame_start_q <= frame_start_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign hcount      = hcount_q;
    assign vcount      = vcount_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign hblnk       = hblnk_q;
    assign vblnk       = vblnk_q;
    assign frame_start = frame_start_q;
    assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_param.sv
// ----------------------------------------------------------------------------
// tb_vga_timing_param
//   Scoreboard bench for vga_timing_param on a small geometry (32 x 17 raster,
//   inverted hsync polarity, 2-bit frame counter). The stimulus process drives
//   random resets (and random ce when VGA_TIMING_CE_EN is defined), advances
//   a linear pixel-index reference model and queues the expected outputs; the
//   monitor process pops and compares one entry per clock.
// ----------------------------------------------------------------------------
module tb_vga_timing_param;

    localparam int unsigned CW   = 6;
    localparam int unsigned FW   = 2;
    localparam int unsigned HA   = 20;
    localparam int unsigned HF   = 3;
    localparam int unsigned HS   = 4;
    localparam int unsigned HB   = 5;
    localparam int unsigned VA   = 10;
    localparam int unsigned VF   = 2;
    localparam int unsigned VS   = 3;
    localparam int unsigned VB   = 2;
    localparam bit          HPOL = 1'b0;
    localparam bit          VPOL = 1'b1;

    localparam int HT     = HA + HF + HS + HB;   // 32
    localparam int VT     = VA + VF + VS + VB;   // 17
    localparam int FT     = HT * VT;             // 544 clocks per frame
    localparam int NCYC   = 12000;
    localparam int FCMOD  = 1 << FW;

    typedef struct packed {
        logic [CW-1:0] h;
        logic [CW-1:0] v;
        logic          hs;
        logic          vs;
        logic          hb;
        logic          vb;
        logic          fs;
        logic [FW-1:0] fc;
    } obs_t;

    logic          clk = 1'b0;
    logic          rst;
`ifdef VGA_TIMING_CE_EN
    logic          ce;
`endif
    logic [CW-1:0] hcount;
    logic [CW-1:0] vcount;
    logic          hsync;
    logic          vsync;
    logic          hblnk;
    logic          vblnk;
    logic          frame_start;
    logic [FW-1:0] frame_cnt;

    obs_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    vga_timing_param #(
        .CNT_W(CW), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .H_SYNC_POL(HPOL), .V_SYNC_POL(VPOL), .FRAME_W(FW)
    ) dut (
        .clk(clk),
        .rst(rst),
`ifdef VGA_TIMING_CE_EN
        .ce(ce),
`endif
        .hcount(hcount),
        .vcount(vcount),
        .hsync(hsync),
        .vsync(vsync),
        .hblnk(hblnk),
        .vblnk(vblnk),
        .frame_start(frame_start),
        .frame_cnt(frame_cnt)
    );

    // Expected outputs from a linear pixel index within the frame.
    function automatic obs_t expect_of(input int pos, input int fc, input bit fs);
        obs_t e;
        int   h;
        int   v;
        h    = pos % HT;
        v    = pos / HT;
        e.h  = CW'(h);
        e.v  = CW'(v);
        e.hb = (h >= HA);
        e.vb = (v >= VA);
        e.hs = (h >= HA + HF && h < HA + HF + HS) ? HPOL : !HPOL;
        e.vs = (v >= VA + VF && v < VA + VF + VS) ? VPOL : !VPOL;
        e.fs = fs;
        e.fc = FW'(fc);
        return e;
    endfunction

    // Stimulus + reference model.
    initial begin
        int pos;
        int fc;
        bit fs;
        bit r;
        bit c;
        pos = 0;
        fc  = 0;
        fs  = 1'b0;
        rst = 1'b1;
`ifdef VGA_TIMING_CE_EN
        ce  = 1'b1;
`endif
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            // Long reset-free stretch first so frame_cnt wraps, one forced
            // mid-frame reset, then sparse random resets.
            r = (cyc < 3) || (cyc == 3000) ||
                (cyc > 3500 && $urandom_range(0, 699) == 0);
`ifdef VGA_TIMING_CE_EN
            c = ($urandom_range(0, 2) != 0);
            ce = c;
`else
            c = 1'b1;
`endif
            rst = r;
            if (r) begin
                pos = 0;
                fc  = 0;
                fs  = 1'b0;
            end else if (c) begin
                pos = (pos + 1) % FT;
                fs  = (pos == 0);
                if (fs) fc = (fc + 1) % FCMOD;
            end else begin
                fs = 1'b0;
            end
            exp_q.push_back(expect_of(pos, fc, fs));
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Monitor: one comparison per clock, sampled after the active edge.
    initial begin
        obs_t e;
        obs_t a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                a = '{h: hcount, v: vcount, hs: hsync, vs: vsync,
                      hb: hblnk, vb: vblnk, fs: frame_start, fc: frame_cnt};
                vectors++;
                if (a !== e) begin
                    miscompares++;
                    $display("FAIL vec %0d @%0t: got h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b fs=%b fc=%0d, want h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b fs=%b fc=%0d",
                             vectors, $time, a.h, a.v, a.hs, a.vs, a.hb, a.vb, a.fs, a.fc,
                             e.h, e.v, e.hs, e.vs, e.hb, e.vb, e.fs, e.fc);
                end
            end
        end
    end

endmodule
